// File: rtl/arbiter_req_stage_pkg.sv
// Shared sizing defaults, the output ID type and the lowest-index grant picker for the request stage.
// Optional checking is enabled by ARB_REQ_STAGE_CHECK_EN, which is consumed in arbiter_req_stage.sv.
package arbiter_req_stage_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef logic [$clog2(DEF_N_REQ)-1:0] id_t;

    // Keeps only the lowest set bit, so a malformed multi-hot grant still pops a single channel.
    function automatic logic [DEF_N_REQ-1:0] onehot_lowest(input logic [DEF_N_REQ-1:0] vec);
        return vec & (~vec + DEF_N_REQ'(1));
    endfunction

endpackage

// File: rtl/req_stage_fifo.sv
// Single-channel circular FIFO: exposes its head word and occupancy count.
// Push and pop take effect in the same cycle; the caller guarantees no push when full and no pop when empty.
module req_stage_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/arbiter_req_stage.sv
// Request staging for the round-robin arbiter: per-channel FIFOs drive req, a grant pops into a registered output.
// Latency push->out_valid is 3 cycles with a registered arbiter; output holds while out_ready is low. Checker under ARB_REQ_STAGE_CHECK_EN.
module arbiter_req_stage
    import arbiter_req_stage_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           in_valid,
    input  logic [N_REQ*DATA_W-1:0]    in_data,
    output logic [N_REQ-1:0]           in_ready,
    output logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           gnt,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    input  logic                       out_ready,
    output logic                       err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ID_W  = $clog2(N_REQ);

    logic [CNT_W-1:0]  w_count [N_REQ];
    logic [DATA_W-1:0] w_head  [N_REQ];
    logic [N_REQ-1:0]  w_full;
    logic [N_REQ-1:0]  w_push;
    logic [N_REQ-1:0]  w_sel;
    logic [N_REQ-1:0]  w_pop;
    logic              w_slot_free;
    id_t               w_sel_id;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    id_t               r_out_id;

    for (genvar g = 0; g < N_REQ; g++) begin : g_ch
        req_stage_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (in_data[g*DATA_W +: DATA_W]),
            .o_head  (w_head[g]),
            .o_count (w_count[g])
        );
        assign w_full[g] = (w_count[g] == CNT_W'(DEPTH));
        assign req[g]    = (w_count[g] != '0);
    end

    assign in_ready    = ~w_full & {N_REQ{rst_n}};
    assign w_push      = in_valid & in_ready;
    assign w_slot_free = !r_out_valid || out_ready;

    // Grants to empty channels are dropped here: the arbiter's grant trails req by a cycle.
    assign w_sel = onehot_lowest(gnt & req);
    assign w_pop = w_slot_free ? w_sel : '0;

    always_comb begin
        w_sel_id   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) begin
                w_sel_id   = ID_W'(i);
                w_sel_data = w_head[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_slot_free) begin
            r_out_valid <= |w_pop;
            if (|w_pop) begin
                r_out_data <= w_sel_data;
                r_out_id   <= w_sel_id;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

`ifdef ARB_REQ_STAGE_CHECK_EN
    logic w_gnt_multi;
    logic w_full_push;
    logic r_err;

    assign w_gnt_multi = (gnt & (gnt - N_REQ'(1))) != '0;
    assign w_full_push = (|(in_valid & w_full)) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_err <= 1'b0;
        else if (w_gnt_multi || w_full_push) r_err <= 1'b1;
    end

    assign err = r_err;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !w_gnt_multi)
        else $error("arbiter_req_stage: non-one-hot grant %b", gnt);
    a_no_full_push: assert property (@(posedge clk) disable iff (!rst_n) !w_full_push)
        else $error("arbiter_req_stage: push to full channel %b", in_valid & w_full);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_req_stage.sv
// Scoreboard bench for arbiter_req_stage: queue-based reference model, directed scenarios then random traffic.
module tb_arbiter_req_stage;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_id;
    logic          out_ready;
    logic          err;

    arbiter_req_stage #(.N_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    logic [7:0] mq [N][$];
    exp_t       sb [$];
    bit         mv;
    bit         err_m;
    bit         run;
    int         checks;
    int         fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one edge of the stage described as queue operations.
    task automatic model_edge(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g, input logic ordy);
        int  cnt [N];
        bit  slot;
        int  win;
        for (int i = 0; i < N; i++) cnt[i] = mq[i].size();
`ifdef ARB_REQ_STAGE_CHECK_EN
        begin
            int ones = 0;
            for (int i = 0; i < N; i++) if (g[i]) ones++;
            if (ones > 1) err_m = 1;
            for (int i = 0; i < N; i++) if (v[i] && cnt[i] == D && ordy) err_m = 1;
        end
`endif
        slot = !mv || ordy;
        win  = -1;
        for (int i = N - 1; i >= 0; i--) if (g[i] && cnt[i] > 0) win = i;
        if (slot && win >= 0) begin
            exp_t e;
            e.id = win;
            e.d  = mq[win].pop_front();
            sb.push_back(e);
            mv = 1;
        end else if (slot) begin
            mv = 0;
        end
        for (int i = 0; i < N; i++) if (v[i] && cnt[i] < D) mq[i].push_back(d[i*W +: W]);
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g, input logic ordy);
        in_valid  = v;
        in_data   = d;
        gnt       = g;
        out_ready = ordy;
        @(posedge clk);
        model_edge(v, d, g, ordy);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        sb.delete();
        mv    = 0;
        err_m = 0;
    endtask

    task automatic reset_checks();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_req", req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_err", err, 0);
    endtask

    // Monitor: compares every live cycle against the model and consumes the scoreboard on handshakes.
    always @(negedge clk) begin
        if (run && rst_n) begin
            logic [3:0] exp_req;
            logic [3:0] exp_rdy;
            for (int i = 0; i < N; i++) begin
                exp_req[i] = mq[i].size() != 0;
                exp_rdy[i] = mq[i].size() < D;
            end
            chk("req", req, exp_req);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, mv);
            chk("err", err, err_m);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("out_id", out_id, sb[0].id);
                    chk("out_data", out_data, sb[0].d);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        checks    = 0;
        fails     = 0;
        run       = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'h5555_5555;
        gnt       = '0;
        out_ready = 1'b1;
        model_clear();

        repeat (2) begin
            @(negedge clk);
            reset_checks();
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        rst_n    = 1'b1;
        run      = 1;
        step(0, 0, 0, 1);

        // Single word through ch2
        step(4'b0100, 32'h00A5_0000, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 4'b0100, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Fill ch0, fifth push stalls until a pop frees a slot
        for (int k = 1; k <= 5; k++) step(4'b0001, k, 0, 1);
        step(4'b0001, 5, 4'b0001, 1);
        step(4'b0001, 5, 4'b0001, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0001, 1);
        step(0, 0, 0, 1);

        // Backpressure with ch0 holding 3 words behind the output register
        for (int k = 0; k < 4; k++) step(4'b0001, 8'h20 + k, 0, 1);
        step(0, 0, 4'b0001, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0001, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0001, 1);
        step(0, 0, 0, 1);

        // Round robin across all channels
        step(4'b1111, {8'd13, 8'd12, 8'd11, 8'd10}, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 4'b0001, 1);
        step(0, 0, 4'b0010, 1);
        step(0, 0, 4'b0100, 1);
        step(0, 0, 4'b1000, 1);
        step(0, 0, 0, 1);

        // Multi-hot grant: lowest index wins
        step(4'b0110, 32'h0077_6600, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 4'b0110, 1);
        step(0, 0, 4'b0100, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            int          r;
            logic [3:0]  g;
            r = $urandom_range(0, 5);
            g = (r >= 1 && r <= 4) ? 4'(1 << (r - 1)) : 4'b0000;
            step(4'($urandom), $urandom, g, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 24; k++) step(0, 0, 4'(1 << (k % 4)), 1);

        // Reset in the middle of traffic discards everything
        step(4'b1111, $urandom, 0, 1);
        step(0, 0, 4'b0001, 0);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 0, 4'b1111, 1);

        run = 0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
